// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: synchronizes SCL/SDA, decodes START/STOP, ACKs its own
// address and each data byte, and presents received bytes with a valid strobe.
module i2c_slave_receiver #(
    parameter logic [6:0] SlaveAddress = 7'h48,
    parameter int         SyncStages   = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDAIn,
    input  logic       AckEnable,
    output logic       SDADriveLow,
    output logic [7:0] DataOut,
    output logic       DataValid,
    output logic [7:0] ByteCount,
    output logic       Busy,
    output logic       StopDetected
);

    localparam int SyncW = (SyncStages < 2) ? 2 : SyncStages;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAddress = 3'd1;
    localparam logic [2:0] StAddrAck = 3'd2;
    localparam logic [2:0] StData    = 3'd3;
    localparam logic [2:0] StDataAck = 3'd4;
    localparam logic [2:0] StIgnore  = 3'd5;

    logic [SyncW-1:0] scl_sync_q, sda_sync_q;
    logic             scl_prev_q, sda_prev_q;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            scl_prev_q <= 1'b0;
            sda_prev_q <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SyncW-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SyncW-2:0], SDAIn};
            scl_prev_q <= scl_sync_q[SyncW-1];
            sda_prev_q <= sda_sync_q[SyncW-1];
        end
    end

    logic scl_cur, sda_cur;
    logic scl_rise, scl_fall, start_evt, stop_evt;

    assign scl_cur   = scl_sync_q[SyncW-1];
    assign sda_cur   = sda_sync_q[SyncW-1];
    assign scl_rise  = !scl_prev_q && scl_cur;
    assign scl_fall  = scl_prev_q && !scl_cur;
    assign start_evt = scl_prev_q && scl_cur && sda_prev_q && !sda_cur;
    assign stop_evt  = scl_prev_q && scl_cur && !sda_prev_q && sda_cur;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [7:0] bytes_q, bytes_d;
    logic       drive_q, drive_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;

    // Bus conditions outrank clock edges; STOP outranks START.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        drive_d = drive_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        stop_d  = 1'b0;
        if (stop_evt) begin
            state_d = StIdle;
            drive_d = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else if (start_evt) begin
            state_d = StAddress;
            cnt_d   = 4'd0;
            bytes_d = 8'd0;
            drive_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StAddress: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_cur};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == SlaveAddress && !shift_q[0]) begin
                            state_d = StAddrAck;
                            drive_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    if (scl_fall) begin
                        state_d = StData;
                        drive_d = 1'b0;
                        cnt_d   = 4'd0;
                    end
                end
                StData: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_cur};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            data_d  = {shift_q[6:0], sda_cur};
                            valid_d = 1'b1;
                            if (bytes_q != 8'hFF) begin
                                bytes_d = bytes_q + 8'd1;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (AckEnable) begin
                            state_d = StDataAck;
                            drive_d = 1'b1;
                        end else begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StIgnore: begin
                    drive_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            bytes_q <= 8'd0;
            drive_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            drive_q <= drive_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            stop_q  <= stop_d;
        end
    end

    assign SDADriveLow  = drive_q;
    assign DataOut      = data_q;
    assign DataValid    = valid_q;
    assign ByteCount    = bytes_q;
    assign Busy         = busy_q;
    assign StopDetected = stop_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: a bit-banged I2C write master on a wired-AND
// SDA line, with a queue of expected bytes checked at every DataValid.
module tb_i2c_slave_receiver;

    localparam int Q = 8;

    logic       clock = 1'b0;
    logic       Reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       AckEnable = 1'b1;
    logic       sda_bus;
    logic       SDADriveLow;
    logic [7:0] DataOut;
    logic       DataValid;
    logic [7:0] ByteCount;
    logic       Busy;
    logic       StopDetected;

    assign sda_bus = sda_m & ~SDADriveLow;

    always #5 clock = ~clock;

    i2c_slave_receiver #(
        .SlaveAddress(7'h48),
        .SyncStages  (2)
    ) dut (
        .clock       (clock),
        .Reset       (Reset),
        .SCL         (scl_m),
        .SDAIn       (sda_bus),
        .AckEnable   (AckEnable),
        .SDADriveLow (SDADriveLow),
        .DataOut     (DataOut),
        .DataValid   (DataValid),
        .ByteCount   (ByteCount),
        .Busy        (Busy),
        .StopDetected(StopDetected)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         valid_cnt = 0;
    int         stop_cnt = 0;
    logic       drive_seen = 1'b0;
    logic       drive_prev = 1'b0;
    int         drive_hi_scl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (DataValid) begin
            valid_cnt++;
            if (exp_q.size() == 0) chk("valid_unexpected", {31'd0, DataValid}, 32'd0);
            else chk("data_out", {24'd0, DataOut}, {24'd0, exp_q.pop_front()});
        end
        if (StopDetected) stop_cnt++;
        if (SDADriveLow) drive_seen = 1'b1;
        if (SDADriveLow != drive_prev && scl_m) drive_hi_scl++;
        drive_prev = SDADriveLow;
    end

    initial begin
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic hold();
        repeat (Q) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hold();
        scl_m = 1'b1; hold();
        sda_m = 1'b0; hold();
        scl_m = 1'b0; hold();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hold();
        scl_m = 1'b1; hold();
        sda_m = 1'b1; hold();
        hold();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; hold();
            scl_m = 1'b1;   hold(); hold();
            scl_m = 1'b0;   hold();
        end
    endtask

    task automatic ack_clock(output logic acked);
        sda_m = 1'b1; hold();
        scl_m = 1'b1; hold();
        acked = ~sda_bus;
        hold();
        scl_m = 1'b0; hold();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits(b, 8);
        ack_clock(acked);
    endtask

    logic acked;
    int   v0, s0;

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_drive", {31'd0, SDADriveLow}, 32'd0);
        chk("rst_dataout", {24'd0, DataOut}, 32'd0);
        chk("rst_valid", {31'd0, DataValid}, 32'd0);
        chk("rst_bytecount", {24'd0, ByteCount}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_stop", {31'd0, StopDetected}, 32'd0);
        Reset = 1'b1;
        hold();

        // Own address, one data byte
        v0 = valid_cnt; s0 = stop_cnt;
        i2c_start();
        send_byte(8'h90, acked);
        chk("t1_addr_ack", {31'd0, acked}, 32'd1);
        chk("t1_busy", {31'd0, Busy}, 32'd1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, acked);
        chk("t1_data_ack", {31'd0, acked}, 32'd1);
        i2c_stop();
        chk("t1_bytecount", {24'd0, ByteCount}, 32'd1);
        chk("t1_dataout", {24'd0, DataOut}, 32'hA5);
        chk("t1_busy_after", {31'd0, Busy}, 32'd0);
        chk("t1_valids", valid_cnt - v0, 32'd1);
        chk("t1_stops", stop_cnt - s0, 32'd1);

        // Foreign address
        v0 = valid_cnt; s0 = stop_cnt; drive_seen = 1'b0;
        i2c_start();
        send_byte(8'h42, acked);
        chk("t2_addr_nack", {31'd0, acked}, 32'd0);
        send_byte(8'h5A, acked);
        chk("t2_data_nack", {31'd0, acked}, 32'd0);
        i2c_stop();
        chk("t2_never_drive", {31'd0, drive_seen}, 32'd0);
        chk("t2_valids", valid_cnt - v0, 32'd0);
        chk("t2_stops", stop_cnt - s0, 32'd1);
        chk("t2_busy", {31'd0, Busy}, 32'd0);

        // Own address with read bit
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h91, acked);
        chk("t3_read_nack", {31'd0, acked}, 32'd0);
        send_byte(8'h33, acked);
        chk("t3_data_nack", {31'd0, acked}, 32'd0);
        chk("t3_busy", {31'd0, Busy}, 32'd0);
        i2c_stop();
        chk("t3_valids", valid_cnt - v0, 32'd0);

        // ACK then NACK of data
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h90, acked);
        chk("t4_addr_ack", {31'd0, acked}, 32'd1);
        exp_q.push_back(8'h11);
        send_byte(8'h11, acked);
        chk("t4_ack_11", {31'd0, acked}, 32'd1);
        AckEnable = 1'b0;
        exp_q.push_back(8'h22);
        send_byte(8'h22, acked);
        chk("t4_nack_22", {31'd0, acked}, 32'd0);
        chk("t4_busy", {31'd0, Busy}, 32'd0);
        chk("t4_dataout", {24'd0, DataOut}, 32'h22);
        AckEnable = 1'b1;
        send_byte(8'h33, acked);
        chk("t4_third_ignored", {31'd0, acked}, 32'd0);
        i2c_stop();
        chk("t4_valids", valid_cnt - v0, 32'd2);
        chk("t4_bytecount", {24'd0, ByteCount}, 32'd2);

        // Partial byte then repeated START
        v0 = valid_cnt;
        i2c_start();
        send_byte(8'h90, acked);
        chk("t5_addr_ack", {31'd0, acked}, 32'd1);
        send_bits(8'hA0, 4);
        i2c_start();
        chk("t5_busy_rs", {31'd0, Busy}, 32'd0);
        send_byte(8'h90, acked);
        chk("t5_addr_ack2", {31'd0, acked}, 32'd1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, acked);
        chk("t5_data_ack", {31'd0, acked}, 32'd1);
        i2c_stop();
        chk("t5_valids", valid_cnt - v0, 32'd1);
        chk("t5_bytecount", {24'd0, ByteCount}, 32'd1);
        chk("t5_dataout", {24'd0, DataOut}, 32'h3C);

        // Reset during the address ACK
        i2c_start();
        send_bits(8'h90, 8);
        chk("t6_drive_pre", {31'd0, SDADriveLow}, 32'd1);
        @(posedge clock);
        #2 Reset = 1'b0;
        #1;
        chk("t6_drive", {31'd0, SDADriveLow}, 32'd0);
        chk("t6_dataout", {24'd0, DataOut}, 32'd0);
        chk("t6_valid", {31'd0, DataValid}, 32'd0);
        chk("t6_bytecount", {24'd0, ByteCount}, 32'd0);
        chk("t6_busy", {31'd0, Busy}, 32'd0);
        chk("t6_stop", {31'd0, StopDetected}, 32'd0);
        @(negedge clock);
        Reset = 1'b1;
        sda_m = 1'b1; hold();
        scl_m = 1'b1; hold(); hold();
        i2c_start();
        send_byte(8'h90, acked);
        chk("t6_addr_ack", {31'd0, acked}, 32'd1);
        exp_q.push_back(8'h77);
        send_byte(8'h77, acked);
        chk("t6_data_ack", {31'd0, acked}, 32'd1);
        i2c_stop();
        chk("t6_bytecount_after", {24'd0, ByteCount}, 32'd1);
        chk("t6_dataout_after", {24'd0, DataOut}, 32'h77);

        repeat (20) @(negedge clock);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("drive_change_scl_high", drive_hi_scl, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
